// File: rtl/instr_loader.sv
// Feeder stage for the instruction register: buffers upstream instructions in a small FIFO,
// screens divide/modulo-by-zero, and issues one register write per cycle with pointer management.
module instr_loader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_ENTRIES = 32,
  parameter bit WRAP_EN     = 1'b1,
  localparam int AW = $clog2(NUM_ENTRIES),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic signed [31:0]   in_operand_a,
  input  logic signed [31:0]   in_operand_b,
  input  logic signed [31:0]   in_operand_c,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 base_load,
  input  logic [AW-1:0]        base_addr,
  output logic                 load_en,
  output logic [AW-1:0]        write_pointer,
  output logic [3:0]           opcode,
  output logic signed [31:0]   operand_a,
  output logic signed [31:0]   operand_b,
  output logic signed [31:0]   operand_c,
  output logic [CW-1:0]        fifo_count,
  output logic [15:0]          wr_count,
  output logic [7:0]           drop_count,
  output logic                 err_div0,
  output logic                 done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(NUM_ENTRIES - 1);

  typedef struct packed {
    logic [3:0]         op;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] c;
  } entry_t;

  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [1:0]      state;
  logic [1:0]      state_next;

  logic            accept;
  logic            is_div0;
  logic            push;
  logic            drop;
  logic            pop;
  logic            stop_hit;
  entry_t          head;

  // in_ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign in_ready = reset_n & ~flush & (fifo_count < DEPTH_C);
  assign accept   = in_valid & in_ready;
  assign is_div0  = ((in_opcode == OP_DIV) || (in_opcode == OP_MOD)) && (in_operand_b == '0);
  assign push     = accept & ~is_div0;
  assign drop     = accept & is_div0;
  assign head     = fifo_mem[rd_ptr];

  // Writing the last entry without wrap must not let another pop slip out behind it.
  assign stop_hit = !WRAP_EN && load_en && (write_pointer == LAST_C);

  assign pop = (state == ST_ISSUE) && (fifo_count != '0) &&
               !hold && !flush && !base_load && !stop_hit;

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:  if (fifo_count != '0) state_next = ST_ISSUE;
      ST_ISSUE: if (fifo_count == '0) state_next = ST_IDLE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase

    if (stop_hit) state_next = ST_DONE;

    if (base_load && (state == ST_DONE || stop_hit)) state_next = ST_IDLE;

    if (flush) state_next = (state == ST_ISSUE) ? ST_IDLE : state;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: in_opcode, a: in_operand_a,
                                    b: in_operand_b, c: in_operand_c};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en   <= 1'b0;
      opcode    <= OP_ZERO;
      operand_a <= '0;
      operand_b <= '0;
      operand_c <= '0;
    end else begin
      load_en <= pop;
      if (pop) begin
        opcode    <= head.op;
        operand_a <= head.a;
        operand_b <= head.b;
        operand_c <= head.c;
      end
    end
  end

  // Pointer and write count advance at the edge that completes each issued write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer <= '0;
      wr_count      <= '0;
    end else if (!flush) begin
      if (load_en) wr_count <= wr_count + 1'b1;
      if (base_load) begin
        write_pointer <= base_addr;
      end else if (load_en) begin
        if (write_pointer != LAST_C) write_pointer <= write_pointer + 1'b1;
        else if (WRAP_EN)            write_pointer <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      err_div0   <= 1'b0;
    end else if (drop) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      err_div0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: one wrapping and one stopping instance share stimulus
// except for in_valid; every observed write is popped against a queue of expected writes.
module tb_instr_loader;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;

  typedef struct packed {
    logic [4:0]  wp;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic v_wrap = 1'b0, v_stop = 1'b0;
  logic [3:0] in_opcode = '0;
  logic signed [31:0] in_a = '0, in_b = '0, in_c = '0;
  logic hold = 1'b0, flush = 1'b0, base_load = 1'b0;
  logic [4:0] base_addr = '0;

  logic w_in_ready, w_load_en, w_err, w_done;
  logic [4:0] w_wp;
  logic [3:0] w_op;
  logic signed [31:0] w_a, w_b, w_c;
  logic [2:0] w_fifo_count;
  logic [15:0] w_wr_count;
  logic [7:0] w_drop_count;

  logic s_in_ready, s_load_en, s_err, s_done;
  logic [4:0] s_wp;
  logic [3:0] s_op;
  logic signed [31:0] s_a, s_b, s_c;
  logic [2:0] s_fifo_count;
  logic [15:0] s_wr_count;
  logic [7:0] s_drop_count;

  wr_t q_w[$];
  wr_t q_s[$];
  int checks = 0;
  int failures = 0;
  int n_wr_w = 0;
  int n_wr_s = 0;

  always #5 clk = ~clk;

  instr_loader #(.FIFO_DEPTH(4), .NUM_ENTRIES(32), .WRAP_EN(1'b1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(v_wrap), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_operand_a(in_a), .in_operand_b(in_b), .in_operand_c(in_c),
    .hold(hold), .flush(flush), .base_load(base_load), .base_addr(base_addr),
    .load_en(w_load_en), .write_pointer(w_wp), .opcode(w_op),
    .operand_a(w_a), .operand_b(w_b), .operand_c(w_c),
    .fifo_count(w_fifo_count), .wr_count(w_wr_count), .drop_count(w_drop_count),
    .err_div0(w_err), .done(w_done)
  );

  instr_loader #(.FIFO_DEPTH(4), .NUM_ENTRIES(32), .WRAP_EN(1'b0)) u_stop (
    .clk(clk), .reset_n(reset_n), .in_valid(v_stop), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_operand_a(in_a), .in_operand_b(in_b), .in_operand_c(in_c),
    .hold(hold), .flush(flush), .base_load(base_load), .base_addr(base_addr),
    .load_en(s_load_en), .write_pointer(s_wp), .opcode(s_op),
    .operand_a(s_a), .operand_b(s_b), .operand_c(s_c),
    .fifo_count(s_fifo_count), .wr_count(s_wr_count), .drop_count(s_drop_count),
    .err_div0(s_err), .done(s_done)
  );

  // Pop-and-compare every write strobe seen after an edge.
  task automatic sb_check();
    wr_t got, exp;
    if (w_load_en) begin
      n_wr_w++;
      checks++;
      got = {w_wp, w_op, w_a, w_b, w_c};
      if (q_w.size() == 0) begin
        failures++;
        $display("FAIL sb_wrap unexpected write got=%h", got);
      end else begin
        exp = q_w.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL sb_wrap write got=%h exp=%h", got, exp);
        end
      end
    end
    if (s_load_en) begin
      n_wr_s++;
      checks++;
      got = {s_wp, s_op, s_a, s_b, s_c};
      if (q_s.size() == 0) begin
        failures++;
        $display("FAIL sb_stop unexpected write got=%h", got);
      end else begin
        exp = q_s.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL sb_stop write got=%h exp=%h", got, exp);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic push_exp(input bit inst, input int wp, input logic [3:0] op,
                          input int a, input int b, input int c);
    wr_t e;
    e = {5'(wp), op, 32'(a), 32'(b), 32'(c)};
    if (inst) q_s.push_back(e);
    else      q_w.push_back(e);
  endtask

  // Present one instruction until accepted; wp < 0 means no write is expected yet.
  task automatic send(input bit inst, input logic [3:0] op, input int a, input int b,
                      input int c, input int wp);
    bit acc = 1'b0;
    int n = 0;
    in_opcode = op; in_a = a; in_b = b; in_c = c;
    if (inst) v_stop = 1'b1; else v_wrap = 1'b1;
    #1;
    while (!acc && n < 50) begin
      acc = inst ? s_in_ready : w_in_ready;
      step();
      n++;
    end
    v_wrap = 1'b0; v_stop = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_accept inst=%0d got=0 exp=1", inst);
    end else if (wp >= 0) begin
      push_exp(inst, wp, op, a, b, c);
    end
  endtask

  task automatic wait_writes(input bit inst, input int target, input int budget);
    int n = 0;
    while ((inst ? n_wr_s : n_wr_w) < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if ((inst ? n_wr_s : n_wr_w) < target) begin
      failures++;
      $display("FAIL wait_writes inst=%0d got=%0d exp=%0d", inst, inst ? n_wr_s : n_wr_w, target);
    end
  endtask

  task automatic apply_reset();
    v_wrap = 0; v_stop = 0; hold = 0; flush = 0; base_load = 0; base_addr = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    send(0, OP_ADD, 11, 22, 33, 0);
    wait_writes(0, n_wr_w + 1, 10);
    send(0, OP_DIV, 1, 0, 1, -1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) send(0, OP_SUB, i, 1, 1, -1);
    checks++;
    if (w_fifo_count !== 3'd3 || w_wp !== 5'd1 || w_drop_count !== 8'd1) begin
      failures++;
      $display("FAIL reset_pre count=%0d wp=%0d drops=%0d exp 3/1/1", w_fifo_count, w_wp, w_drop_count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({w_load_en, w_wp, w_op, w_a, w_b, w_c} !== '0) begin
      failures++;
      $display("FAIL reset_outputs en=%b wp=%0d op=%0d a=%0d b=%0d c=%0d exp all 0",
               w_load_en, w_wp, w_op, w_a, w_b, w_c);
    end
    checks++;
    if ({w_fifo_count, w_wr_count, w_drop_count, w_err, w_done, w_in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_status count=%0d wr=%0d drop=%0d err=%b done=%b rdy=%b exp all 0",
               w_fifo_count, w_wr_count, w_drop_count, w_err, w_done, w_in_ready);
    end
    step();
    reset_n = 1'b1;
    hold = 1'b0;
    #1;
    checks++;
    if (w_in_ready !== 1'b1 || w_fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_release rdy=%b count=%0d exp 1/0", w_in_ready, w_fifo_count);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_latency();
    apply_reset();
    in_opcode = OP_ADD; in_a = 5; in_b = 3; in_c = 2; v_wrap = 1'b1;
    push_exp(0, 0, OP_ADD, 5, 3, 2);
    step();
    v_wrap = 1'b0;
    checks++;
    if (w_fifo_count !== 3'd1 || w_load_en !== 1'b0) begin
      failures++;
      $display("FAIL lat_edge1 count=%0d en=%b exp 1/0", w_fifo_count, w_load_en);
    end
    step();
    checks++;
    if (w_load_en !== 1'b0) begin
      failures++;
      $display("FAIL lat_edge2 en=%b exp 0", w_load_en);
    end
    step();
    checks++;
    if (w_load_en !== 1'b1 || w_wp !== 5'd0 || w_op !== OP_ADD ||
        w_a !== 5 || w_b !== 3 || w_c !== 2) begin
      failures++;
      $display("FAIL lat_edge3 en=%b wp=%0d op=%0d a=%0d b=%0d c=%0d exp 1/0/1/5/3/2",
               w_load_en, w_wp, w_op, w_a, w_b, w_c);
    end
    step();
    checks++;
    if (w_load_en !== 1'b0 || w_wp !== 5'd1 || w_wr_count !== 16'd1 || w_a !== 5) begin
      failures++;
      $display("FAIL lat_edge4 en=%b wp=%0d wr=%0d a=%0d exp 0/1/1/5", w_load_en, w_wp, w_wr_count, w_a);
    end
  endtask

  task automatic test_backpressure();
    bit acc5 = 1'b0;
    bit rdy;
    int base;
    apply_reset();
    base = n_wr_w;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(0, OP_SUB, 100 + i, i + 1, 7, i);
    in_opcode = OP_SUB; in_a = 200; in_b = 9; in_c = 1; v_wrap = 1'b1;
    #1;
    checks++;
    if (w_in_ready !== 1'b0 || w_fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL bp_full rdy=%b count=%0d exp 0/4", w_in_ready, w_fifo_count);
    end
    step();
    step();
    checks++;
    if (w_fifo_count !== 3'd4 || n_wr_w !== base) begin
      failures++;
      $display("FAIL bp_stall count=%0d writes=%0d exp 4/%0d", w_fifo_count, n_wr_w, base);
    end
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdy = w_in_ready;
      step();
      if (rdy && !acc5) begin
        acc5 = 1'b1;
        v_wrap = 1'b0;
        push_exp(0, 4, OP_SUB, 200, 9, 1);
      end
      checks++;
      if (w_load_en !== 1'b1 || w_wp !== 5'(k)) begin
        failures++;
        $display("FAIL bp_burst k=%0d en=%b wp=%0d exp 1/%0d", k, w_load_en, w_wp, k);
      end
    end
    v_wrap = 1'b0;
    checks++;
    if (!acc5) begin
      failures++;
      $display("FAIL bp_fifth_accept got=0 exp=1");
    end
    wait_writes(0, base + 5, 20);
  endtask

  task automatic test_div0();
    int base;
    apply_reset();
    base = n_wr_w;
    send(0, OP_DIV, 10, 0, 5, -1);
    #1;
    checks++;
    if (w_drop_count !== 8'd1 || w_err !== 1'b1 || w_fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL div0_first drop=%0d err=%b count=%0d exp 1/1/0", w_drop_count, w_err, w_fifo_count);
    end
    send(0, OP_MOD, 7, 0, 5, -1);
    send(0, OP_DIV, 10, 2, 3, 0);
    wait_writes(0, base + 1, 20);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (w_drop_count !== 8'd2 || w_err !== 1'b1 || w_wr_count !== 16'd1 || n_wr_w !== base + 1) begin
      failures++;
      $display("FAIL div0_final drop=%0d err=%b wr=%0d writes=%0d exp 2/1/1/%0d",
               w_drop_count, w_err, w_wr_count, n_wr_w, base + 1);
    end
  endtask

  task automatic test_wrap();
    int base;
    apply_reset();
    base = n_wr_w;
    base_addr = 5'd30; base_load = 1'b1;
    step();
    base_load = 1'b0;
    checks++;
    if (w_wp !== 5'd30) begin
      failures++;
      $display("FAIL wrap_base wp=%0d exp 30", w_wp);
    end
    send(0, OP_ADD, 1, 2, 3, 30);
    send(0, OP_ADD, 4, 5, 6, 31);
    send(0, OP_ADD, 7, 8, 9, 0);
    wait_writes(0, base + 3, 20);
    step();
    checks++;
    if (w_wp !== 5'd1 || w_wr_count !== 16'd3 || w_done !== 1'b0) begin
      failures++;
      $display("FAIL wrap_final wp=%0d wr=%0d done=%b exp 1/3/0", w_wp, w_wr_count, w_done);
    end
  endtask

  task automatic test_stop();
    int base;
    apply_reset();
    base = n_wr_s;
    base_addr = 5'd30; base_load = 1'b1;
    step();
    base_load = 1'b0;
    send(1, OP_ADD, 1, 2, 3, 30);
    send(1, OP_ADD, 4, 5, 6, 31);
    send(1, OP_ADD, 7, 8, 9, 0);
    wait_writes(1, base + 2, 20);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (s_done !== 1'b1 || s_fifo_count !== 3'd1 || s_wp !== 5'd31 ||
        s_wr_count !== 16'd2 || n_wr_s !== base + 2) begin
      failures++;
      $display("FAIL stop_done done=%b count=%0d wp=%0d wr=%0d writes=%0d exp 1/1/31/2/%0d",
               s_done, s_fifo_count, s_wp, s_wr_count, n_wr_s, base + 2);
    end
    base_addr = 5'd0; base_load = 1'b1;
    step();
    base_load = 1'b0;
    checks++;
    if (s_done !== 1'b0 || s_wp !== 5'd0) begin
      failures++;
      $display("FAIL stop_rebase done=%b wp=%0d exp 0/0", s_done, s_wp);
    end
    wait_writes(1, base + 3, 20);
    step();
    checks++;
    if (s_fifo_count !== 3'd0 || s_wp !== 5'd1 || s_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_final count=%0d wp=%0d done=%b exp 0/1/0", s_fifo_count, s_wp, s_done);
    end
  endtask

  task automatic test_flush();
    int base;
    apply_reset();
    base_addr = 5'd7; base_load = 1'b1;
    step();
    base_load = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) send(0, OP_SUB, 50 + i, 1, 1, -1);
    checks++;
    if (w_fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL flush_pre count=%0d exp 3", w_fifo_count);
    end
    flush = 1'b1;
    in_opcode = OP_ADD; in_a = 99; in_b = 1; in_c = 1; v_wrap = 1'b1;
    #1;
    checks++;
    if (w_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready rdy=%b exp 0", w_in_ready);
    end
    step();
    flush = 1'b0;
    v_wrap = 1'b0;
    checks++;
    if (w_fifo_count !== 3'd0 || w_load_en !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear count=%0d en=%b exp 0/0", w_fifo_count, w_load_en);
    end
    hold = 1'b0;
    base = n_wr_w;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (n_wr_w !== base || w_wp !== 5'd7 || w_wr_count !== 16'd0) begin
      failures++;
      $display("FAIL flush_state writes=%0d wp=%0d wr=%0d exp %0d/7/0", n_wr_w, w_wp, w_wr_count, base);
    end
    send(0, OP_ADD, 3, 4, 5, 7);
    wait_writes(0, base + 1, 20);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_div0();
    test_wrap();
    test_stop();
    test_flush();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (q_w.size() != 0 || q_s.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending_wrap=%0d pending_stop=%0d exp 0/0", q_w.size(), q_s.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream feeder stage for the 32-entry instruction register.
- Accepts instructions from the stimulus/generator side over a valid/ready handshake and buffers them in a small FIFO.
- Issues one write per cycle into the register by driving load_en, write_pointer, opcode and operands.
- Screens divide/modulo-by-zero instructions before they reach the register, and manages write-pointer advance, wrap and stop.

Parameters:
- FIFO_DEPTH, 4, input buffer depth in entries (power of 2, >= 2).
- NUM_ENTRIES, 32, register depth; write_pointer range is 0..NUM_ENTRIES-1.
- WRAP_EN, 1, 1 = write_pointer wraps to 0 after the last entry; 0 = stop issuing after the last entry.

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  loader can accept an instruction
- in_opcode  input  opcode_t (4)  instruction opcode
- in_operand_a  input  operand_t (32, signed)  operand a
- in_operand_b  input  operand_t (32, signed)  operand b
- in_operand_c  input  operand_t (32, signed)  operand c
- hold  input  1  pause issue; FIFO still accepts
- flush  input  1  discard all buffered instructions
- base_load  input  1  load write_pointer from base_addr
- base_addr  input  address_t (5)  new write_pointer value
- load_en  output  1  write strobe to the register
- write_pointer  output  address_t (5)  target entry
- opcode  output  opcode_t (4)  to the register
- operand_a, operand_b, operand_c  output  operand_t (32) each  to the register
- fifo_count  output  3  entries currently buffered (0..FIFO_DEPTH)
- wr_count  output  16  total writes issued, wraps at 2^16
- drop_count  output  8  div/mod-by-zero instructions dropped, saturates at 255
- err_div0  output  1  sticky, set on the first drop
- done  output  1  high in the DONE state

Behaviour:
- Reset: while reset_n is low the block is held in reset.
  - load_en=0, write_pointer=0, opcode=ZERO, operands=0.
  - fifo_count=0, wr_count=0, drop_count=0, err_div0=0, done=0, in_ready=0.
  - State=IDLE, FIFO emptied.
  - An asserted reset mid-operation discards everything, including buffered instructions.
- Output registration: all outputs are registered, except in_ready.
  - in_ready = reset_n & !flush & (fifo_count < FIFO_DEPTH), with fifo_count taken from the current cycle.
  - A pop in the same cycle does not free a slot for a push.
- Accept: occurs when in_valid & in_ready at a rising edge.
  - If in_opcode is DIV or MOD and in_operand_b==0: the handshake completes but nothing is pushed; drop_count increments (saturating) and err_div0 is set.
  - Otherwise the instruction is pushed to the FIFO tail.
- States:
  - IDLE: FIFO empty. Moves to ISSUE when fifo_count>0.
  - ISSUE: each cycle with fifo_count>0 and hold=0, pop the head. Next cycle drives load_en=1 with the popped fields and the current write_pointer. Returns to IDLE when the FIFO is empty.
  - DONE: entered only when WRAP_EN=0 and a write targets entry NUM_ENTRIES-1. load_en stays 0 and the FIFO keeps filling. Exits to IDLE only on base_load.
- Latency: an instruction accepted at edge N into an empty FIFO with hold=0 gives load_en=1 after edge N+2, and the register captures it at edge N+3.
  - Back-to-back issue sustains 1 write/cycle.
  - load_en is a single-cycle pulse per instruction.
  - Operand outputs hold their last value when load_en=0.
- Pointer: write_pointer increments by 1 on the edge after each issued write (wr_count increments at the same edge).
  - At NUM_ENTRIES-1 it wraps to 0 if WRAP_EN=1.
  - If WRAP_EN=0 it holds at NUM_ENTRIES-1 and the block enters DONE.
- base_load: write_pointer<=base_addr.
  - base_load has priority over issue; no pop occurs in that cycle.
  - In DONE, base_load returns the block to IDLE.
- flush: FIFO cleared at the edge, no pop or push that cycle, load_en=0 the next cycle.
  - Pointer, counters and state are unchanged, except that ISSUE goes to IDLE.
- hold: freezes popping only. A load_en already registered still completes.
- Priority for the same edge: reset > flush > base_load > issue.

Test Plan:
- Reset values: assert reset_n=0 mid-burst with 3 entries buffered.
  - Required: all outputs zero/ZERO immediately, in_ready=0.
  - After release: in_ready=1, fifo_count=0, and no load_en.
- Basic latency: push ADD a=5 b=3 c=2 at edge 1 into an empty FIFO.
  - Required: load_en=1 after edge 3 with write_pointer=0, opcode=ADD, operands 5/3/2.
  - Required: write_pointer=1 and wr_count=1 after edge 4.
- Backpressure: set hold=1 and push 5 instructions.
  - Required: in_ready drops after 4 are accepted, fifo_count=4, 5th stalls.
  - Release hold: 4 consecutive load_en pulses with write_pointer 0,1,2,3, then the 5th is accepted.
- Div-by-zero screen: push DIV a=10 b=0, then MOD a=7 b=0, then DIV a=10 b=2.
  - Required: drop_count=2, err_div0=1.
  - Required: a single load_en with DIV 10/2 at write_pointer=0.
- Wrap/stop:
  - WRAP_EN=1, base_addr=30 via base_load, push 3 → writes to 30, 31, 0.
  - WRAP_EN=0, same stimulus → writes to 30, 31, then done=1 and the 3rd instruction stays buffered (fifo_count=1).
  - base_load base_addr=0 → the buffered instruction writes to entry 0.
- Flush collision: with 3 buffered, assert flush and in_valid together in the same cycle.
  - Required: no accept, fifo_count=0 next cycle, no load_en.
  - Required: write_pointer and wr_count unchanged.
